fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write arbiter that lets N_REQ producers share the write port of the team's 32-bit, 8-deep FIFO. It tracks FIFO occupancy with an internal credit counter, grants one requester per cycle, and drives registered `fifo_wr`/`fifo_din`/`fifo_en` into the FIFO. It sits between the producer blocks and the FIFO write side; the FIFO's consumer reports each pop back to the arbiter.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `DATA_W`, 32, data width
- `DEPTH`, 8, FIFO depth = initial credits
- `BURST_LEN`, 4, max consecutive beats per grant (used only with burst lock compiled in)

Ports:
- `clk`  in  1  clock; reset `rst`, synchronous, active-high, clock `clk`
- `rst`  in  1  synchronous active-high reset
- `req_valid`  in  N_REQ  per-requester word valid
- `req_data`  in  N_REQ*DATA_W  requester i data at bits [i*DATA_W +: DATA_W]
- `req_ready`  out  N_REQ  one-hot accept, combinational
- `fifo_pop`  in  1  consumer read one word from FIFO this cycle
- `fifo_en`  out  1  FIFO enable
- `fifo_wr`  out  1  FIFO write strobe
- `fifo_din`  out  DATA_W  FIFO write data
- `grant_id`  out  clog2(N_REQ)  index of last accepted requester
- `credits`  out  clog2(DEPTH+1)  free FIFO slots
- `err`  out  1  sticky: pop seen with credits == DEPTH

## Operation
- Reset values: `fifo_en`=0, `fifo_wr`=0, `fifo_din`=0, `grant_id`=0, `credits`=DEPTH, `err`=0, priority pointer `ptr`=0, state IDLE. `req_ready`=0 while `rst` is high.
- Winner: first i with `req_valid[i]`, searching from `ptr` upward modulo N_REQ.
- `req_ready[winner]`=1 iff winner exists, `credits`!=0, `rst`=0. All other bits are 0.
- Transfer: valid & ready at a rising edge. The requester holds data stable until then.
- On transfer: `fifo_wr`<=1, `fifo_din`<=winner data, `grant_id`<=winner. Otherwise `fifo_wr`<=0 and `fifo_din` holds its value.
- Credits: next = credits − accept + pop. Accept and pop in the same cycle leave credits unchanged. A pop in the same cycle does not unblock a write when `credits`=0.
- A pop when `credits`=DEPTH is ignored (no increment) and sets `err`. Only `rst` clears `err`.
- `fifo_en`<=1 on the first cycle after `rst` deasserts, then stays 1.
- States:
  - IDLE: no transfer last cycle.
  - GRANT: transfer made.
  - STALL: valid present but `credits`=0.
  - Transitions are evaluated every cycle from accept, valid and credit status.
- Pointer without burst lock: `ptr`<=winner+1 (mod N_REQ) after each transfer.
- Wrap: `ptr` wraps from N_REQ−1 to 0.

## Timing
- Acceptance to `fifo_wr` high: 1 cycle. The FIFO stores the word on the following edge.
- Sustained throughput: 1 word/cycle while credits remain. No bubble when switching requesters.
- `credits` reaches 0 after DEPTH back-to-back accepts with no pops. `req_ready` is 0 in that same cycle.
- Reset mid-operation:
  - The in-flight `fifo_wr` is cleared on the reset edge.
  - The FIFO must be reset in the same cycle.
  - Credits return to DEPTH.

## Configuration
- Macro `FIFO_ARB_BURST_LOCK_EN` defined: adds state BURST.
  - After a transfer from requester i, the arbiter stays locked to i while `req_valid[i]` is high, `credits`!=0, and the beat count is < BURST_LEN.
  - While locked, other requesters see `req_ready`=0.
  - The lock ends on the BURST_LEN-th beat, on a `req_valid[i]` drop, or at `credits`=0. Then `ptr`<=i+1.
  - The beat counter resets to 0 when the lock ends.
- Macro undefined: no BURST state and no beat counter. `ptr` advances after every transfer; `BURST_LEN` is unused.

## Test plan
- Reset, then `req_valid`=4'b0001 with data 32'h0..32'h4 for 5 cycles, no pops -> `fifo_din`=0..4 on consecutive cycles (each one cycle after accept), `credits`=3.
- All 4 requesters valid continuously, lock disabled -> grant order 0,1,2,3,0,1,2,3. `req_ready` stays 0 after 8 accepts with no pops; state STALL.
- Credits at 0 and one `fifo_pop` -> one accept on the next cycle, then stall again. Pop and accept in the same cycle at `credits`=3 -> `credits` stays 3.
- `fifo_pop` with `credits`=8 -> `err`=1 and `credits` stays 8; `rst` clears `err`.
- Lock enabled, BURST_LEN=4, requesters 0 and 2 always valid -> beats 0,0,0,0,2,2,2,2. Requester 0 dropping valid after 2 beats -> grant passes to 2 the next cycle.
- `rst` asserted mid-stream -> `fifo_wr`=0, `req_ready`=0, `credits`=8, `fifo_en`=0. `fifo_en`=1 one cycle after release.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Bundle between the producers, the FIFO write/pop side and fifo_wr_arbiter.
// slave modport: the arbiter. master modport: the environment driving it.
// Handshake: a word moves from requester i when req_valid[i] and
// req_ready[i] are both high at a rising clk edge. The requester holds
// req_data stable until then, and req_ready is never more than one-hot.
// dbg_state mirrors the arbiter FSM: 0 IDLE, 1 GRANT, 2 STALL, 3 BURST.
interface fifo_wr_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
);
  localparam int GID_W = $clog2(N_REQ);
  localparam int CRD_W = $clog2(DEPTH + 1);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    fifo_pop;
  logic                    fifo_en;
  logic                    fifo_wr;
  logic [DATA_W-1:0]       fifo_din;
  logic [GID_W-1:0]        grant_id;
  logic [CRD_W-1:0]        credits;
  logic                    err;
  logic [1:0]              dbg_state;

  modport slave (
    input  req_valid, req_data, fifo_pop,
    output req_ready, fifo_en, fifo_wr, fifo_din, grant_id, credits, err, dbg_state
  );

  modport master (
    output req_valid, req_data, fifo_pop,
    input  req_ready, fifo_en, fifo_wr, fifo_din, grant_id, credits, err, dbg_state
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter in front of an 8-deep FIFO. A credit counter
// tracks free FIFO slots; one requester is accepted per cycle and its word
// is written to the FIFO one cycle later through registered outputs.
// Optional burst lock: define FIFO_ARB_BURST_LOCK_EN to keep the grant on
// one requester for up to BURST_LEN consecutive beats.
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 8,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  fifo_wr_arbiter_if.slave  io_bus
);
  localparam int GID_W = $clog2(N_REQ);
  localparam int CRD_W = $clog2(DEPTH + 1);
  localparam logic [CRD_W-1:0] CRD_FULL = CRD_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_STALL = 2'd2,
    S_BURST = 2'd3
  } state_t;

  state_t             r_state;
  logic [GID_W-1:0]   r_ptr;
  logic [CRD_W-1:0]   r_credits;
  logic               r_err;
  logic               r_fifo_en;
  logic               r_fifo_wr;
  logic [DATA_W-1:0]  r_fifo_din;
  logic [GID_W-1:0]   r_grant_id;

  logic               w_found;
  logic [GID_W-1:0]   w_winner;
  logic [GID_W-1:0]   w_idx;
  logic [N_REQ-1:0]   w_ready;
  logic               w_accept;
  logic               w_pop_ok;
  logic [CRD_W-1:0]   w_credits_nxt;
  logic [DATA_W-1:0]  w_data;
  logic               w_lock_next;

`ifdef FIFO_ARB_BURST_LOCK_EN
  localparam int BEAT_W = $clog2(BURST_LEN + 1);
  logic               r_locked;
  logic [GID_W-1:0]   r_lock_id;
  logic [BEAT_W-1:0]  r_beat_cnt;
  logic               w_lock_active;
  logic [BEAT_W-1:0]  w_beat_nxt;

  // A lock only holds while its owner keeps valid up and slots remain.
  assign w_lock_active = r_locked && io_bus.req_valid[r_lock_id] && (r_credits != '0);
  assign w_beat_nxt    = w_lock_active ? (r_beat_cnt + 1'b1) : BEAT_W'(1);
  assign w_lock_next   = w_accept && (w_beat_nxt < BEAT_W'(BURST_LEN));
`else
  assign w_lock_next   = 1'b0;
`endif

  // Winner search: first valid requester starting at r_ptr, wrapping round.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = GID_W'((int'(r_ptr) + k) % N_REQ);
      if (!w_found && io_bus.req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
`ifdef FIFO_ARB_BURST_LOCK_EN
    if (w_lock_active) begin
      w_found  = 1'b1;
      w_winner = r_lock_id;
    end
`endif
  end

  // One-hot ready: only with a winner, a free slot and outside reset.
  always_comb begin
    w_ready = '0;
    if (!rst && w_found && (r_credits != '0)) begin
      w_ready[w_winner] = 1'b1;
    end
  end

  assign w_accept = |(w_ready & io_bus.req_valid);
  assign w_data   = io_bus.req_data[int'(w_winner)*DATA_W +: DATA_W];
  // A pop against a full credit count is bogus and must not overflow credits.
  assign w_pop_ok = io_bus.fifo_pop && (r_credits != CRD_FULL);

  // Credit arithmetic: accept consumes a slot, a valid pop returns one.
  always_comb begin
    w_credits_nxt = r_credits;
    if (w_accept && !w_pop_ok) begin
      w_credits_nxt = r_credits - 1'b1;
    end else if (!w_accept && w_pop_ok) begin
      w_credits_nxt = r_credits + 1'b1;
    end
  end

  // Write-side datapath, credits, pointer and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fifo_en  <= 1'b0;
      r_fifo_wr  <= 1'b0;
      r_fifo_din <= '0;
      r_grant_id <= '0;
      r_ptr      <= '0;
      r_credits  <= CRD_FULL;
      r_err      <= 1'b0;
    end else begin
      r_fifo_en <= 1'b1;
      r_fifo_wr <= w_accept;
      r_credits <= w_credits_nxt;
      if (w_accept) begin
        r_fifo_din <= w_data;
        r_grant_id <= w_winner;
        // Pointer always moves past the last winner; a burst lock overrides
        // the search, so when the lock ends the search resumes at i+1.
        if (w_winner == GID_W'(N_REQ - 1)) begin
          r_ptr <= '0;
        end else begin
          r_ptr <= w_winner + 1'b1;
        end
      end
      if (io_bus.fifo_pop && (r_credits == CRD_FULL)) begin
        r_err <= 1'b1;
      end
    end
  end

  // Arbiter FSM (plus burst lock bookkeeping when compiled in).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
`ifdef FIFO_ARB_BURST_LOCK_EN
      r_locked   <= 1'b0;
      r_lock_id  <= '0;
      r_beat_cnt <= '0;
`endif
    end else begin
      if (w_accept) begin
        r_state <= w_lock_next ? S_BURST : S_GRANT;
      end else if ((|io_bus.req_valid) && (r_credits == '0)) begin
        r_state <= S_STALL;
      end else begin
        r_state <= S_IDLE;
      end
`ifdef FIFO_ARB_BURST_LOCK_EN
      if (w_accept) begin
        r_locked   <= w_lock_next;
        r_lock_id  <= w_winner;
        r_beat_cnt <= w_lock_next ? w_beat_nxt : '0;
      end else begin
        r_locked   <= 1'b0;
        r_beat_cnt <= '0;
      end
`endif
    end
  end

  assign io_bus.req_ready = w_ready;
  assign io_bus.fifo_en   = r_fifo_en;
  assign io_bus.fifo_wr   = r_fifo_wr;
  assign io_bus.fifo_din  = r_fifo_din;
  assign io_bus.grant_id  = r_grant_id;
  assign io_bus.credits   = r_credits;
  assign io_bus.err       = r_err;
  assign io_bus.dbg_state = r_state;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (N_REQ=4, DATA_W=32, DEPTH=8).
module tb_fifo_wr_arbiter;
  localparam int N_REQ  = 4;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;
  localparam logic [1:0] ST_BURST = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_pass   = 0;
  int n_checks = 0;
  logic [DATA_W-1:0] exp_q[$];

  fifo_wr_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  fifo_wr_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .DEPTH(DEPTH), .BURST_LEN(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  // Comparison helper
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_data(input int idx, input logic [DATA_W-1:0] val);
    bus.req_data[idx*DATA_W +: DATA_W] = val;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.fifo_pop  = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Scoreboard: every FIFO write must match the next expected word
  always @(negedge clk) begin
    if (bus.fifo_wr === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("fifo_din_unexpected_write", 64'(bus.fifo_din), 64'hDEAD_0000_0000_0000);
      end else begin
        chk("fifo_din", 64'(bus.fifo_din), 64'(exp_q.pop_front()));
      end
    end
  end

  logic [N_REQ-1:0] oh;
  int ids[8] = '{0, 0, 0, 0, 2, 2, 2, 2};

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.fifo_pop  = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_fifo_en", 64'(bus.fifo_en), 64'd0);
    chk("rst_fifo_wr", 64'(bus.fifo_wr), 64'd0);
    chk("rst_fifo_din", 64'(bus.fifo_din), 64'd0);
    chk("rst_grant_id", 64'(bus.grant_id), 64'd0);
    chk("rst_credits", 64'(bus.credits), 64'd8);
    chk("rst_err", 64'(bus.err), 64'd0);
    chk("rst_state", 64'(bus.dbg_state), 64'(ST_IDLE));
    bus.req_valid = 4'b1111;
    settle();
    chk("rst_ready_blocked", 64'(bus.req_ready), 64'd0);
    bus.req_valid = '0;
    rst = 1'b0;
    settle();
    chk("fifo_en_before_edge", 64'(bus.fifo_en), 64'd0);
    tick();
    chk("fifo_en_after_release", 64'(bus.fifo_en), 64'd1);

    // Single requester, words 0..4, no pops
    for (int i = 0; i < 5; i++) begin
      bus.req_valid = 4'b0001;
      set_data(0, DATA_W'(i));
      settle();
      chk("single_ready", 64'(bus.req_ready), 64'b0001);
      exp_q.push_back(DATA_W'(i));
      tick();
      chk("single_credits", 64'(bus.credits), 64'(7 - i));
      chk("single_wr", 64'(bus.fifo_wr), 64'd1);
    end
    bus.req_valid = '0;
    tick();
    chk("single_wr_drop", 64'(bus.fifo_wr), 64'd0);
    chk("single_din_hold", 64'(bus.fifo_din), 64'd4);
    chk("single_credits_end", 64'(bus.credits), 64'd3);

    // Pop and accept together at credits=3
    bus.req_valid = 4'b0001;
    set_data(0, 32'h5);
    bus.fifo_pop = 1'b1;
    settle();
    chk("popacc_ready", 64'(bus.req_ready), 64'b0001);
    exp_q.push_back(32'h5);
    tick();
    chk("popacc_credits", 64'(bus.credits), 64'd3);
    bus.req_valid = '0;

    // Pops refill credits to 8, then an extra pop flags err
    for (int i = 0; i < 5; i++) tick();
    chk("refill_credits", 64'(bus.credits), 64'd8);
    chk("refill_err", 64'(bus.err), 64'd0);
    tick();
    chk("overpop_err", 64'(bus.err), 64'd1);
    chk("overpop_credits", 64'(bus.credits), 64'd8);
    bus.fifo_pop = 1'b0;
    tick();
    chk("err_sticky", 64'(bus.err), 64'd1);
    rst = 1'b1;
    tick();
    chk("rst_clears_err", 64'(bus.err), 64'd0);
    rst = 1'b0;
    tick();

`ifndef FIFO_ARB_BURST_LOCK_EN
    // All four valid: round robin 0,1,2,3,0,1,2,3 then stall
    for (int r = 0; r < N_REQ; r++) set_data(r, DATA_W'(32'hA0 + r));
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      settle();
      oh = '0;
      oh[i % 4] = 1'b1;
      chk("rr_ready", 64'(bus.req_ready), 64'(oh));
      exp_q.push_back(DATA_W'(32'hA0 + (i % 4)));
      tick();
      chk("rr_grant_id", 64'(bus.grant_id), 64'(i % 4));
      chk("rr_credits", 64'(bus.credits), 64'(7 - i));
    end
    settle();
    chk("full_ready_zero", 64'(bus.req_ready), 64'd0);
    tick();
    chk("full_state_stall", 64'(bus.dbg_state), 64'(ST_STALL));
    chk("full_wr_zero", 64'(bus.fifo_wr), 64'd0);

    // One pop at credits=0: no same-cycle accept, one accept next cycle
    bus.fifo_pop = 1'b1;
    settle();
    chk("pop_at_zero_ready", 64'(bus.req_ready), 64'd0);
    tick();
    bus.fifo_pop = 1'b0;
    chk("pop_at_zero_credits", 64'(bus.credits), 64'd1);
    chk("pop_at_zero_no_wr", 64'(bus.fifo_wr), 64'd0);
    settle();
    chk("after_pop_ready", 64'(bus.req_ready), 64'b0001);
    exp_q.push_back(32'hA0);
    tick();
    chk("after_pop_credits", 64'(bus.credits), 64'd0);
    chk("after_pop_grant", 64'(bus.grant_id), 64'd0);
    settle();
    chk("restall_ready", 64'(bus.req_ready), 64'd0);
    tick();
    chk("restall_state", 64'(bus.dbg_state), 64'(ST_STALL));
    bus.req_valid = '0;
`else
    // Burst lock: requesters 0 and 2 always valid -> 0,0,0,0,2,2,2,2
    set_data(0, 32'hB0);
    set_data(2, 32'hB2);
    bus.req_valid = 4'b0101;
    for (int i = 0; i < 8; i++) begin
      settle();
      oh = '0;
      oh[ids[i]] = 1'b1;
      chk("burst_ready", 64'(bus.req_ready), 64'(oh));
      exp_q.push_back(DATA_W'(32'hB0 + ids[i]));
      tick();
      chk("burst_grant", 64'(bus.grant_id), 64'(ids[i]));
      chk("burst_state", 64'(bus.dbg_state), 64'((i % 4 == 3) ? ST_GRANT : ST_BURST));
    end
    do_reset();
    // Requester 0 drops valid after two beats: grant moves to 2 at once
    bus.req_valid = 4'b0101;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("drop_ready0", 64'(bus.req_ready), 64'b0001);
      exp_q.push_back(32'hB0);
      tick();
    end
    bus.req_valid = 4'b0100;
    settle();
    chk("drop_ready2", 64'(bus.req_ready), 64'b0100);
    exp_q.push_back(32'hB2);
    tick();
    chk("drop_grant2", 64'(bus.grant_id), 64'd2);
    bus.req_valid = '0;
`endif

    // Reset mid-stream with a write in flight
    do_reset();
    bus.req_valid = 4'b0001;
    set_data(0, 32'h77);
    settle();
    exp_q.push_back(32'h77);
    tick();
    chk("inflight_wr", 64'(bus.fifo_wr), 64'd1);
    rst = 1'b1;
    settle();
    chk("midrst_ready", 64'(bus.req_ready), 64'd0);
    tick();
    chk("midrst_wr", 64'(bus.fifo_wr), 64'd0);
    chk("midrst_credits", 64'(bus.credits), 64'd8);
    chk("midrst_fifo_en", 64'(bus.fifo_en), 64'd0);
    chk("midrst_state", 64'(bus.dbg_state), 64'(ST_IDLE));
    rst = 1'b0;
    bus.req_valid = '0;
    tick();
    chk("release_fifo_en", 64'(bus.fifo_en), 64'd1);
    tick();

    // Final report
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
